// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input port for slow external pins: 2-FF synchroniser, optional
// per-bit debounce, sticky edge capture with write-1-to-clear, maskable irq.
module avalon_pio_in_edge #(
    parameter int unsigned          WIDTH           = 2,
    parameter int unsigned          DEBOUNCE_CYCLES = 0,
    parameter int unsigned          EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0]     IRQ_RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [31:0] DEBOUNCE_WORD = DEBOUNCE_CYCLES;
    localparam logic [31:0] MODE_WORD     = EDGE_MODE;
    localparam logic [31:0] INFO_WORD     = {DEBOUNCE_WORD[15:0], 14'b0, MODE_WORD[1:0]};

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic [31:0]      read_mux;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;
    assign wr_en = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt [WIDTH];

            // A bit must differ from its accepted value for DEBOUNCE_CYCLES
            // consecutive cycles; any return to the accepted value restarts it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2[i] == stable[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] >= CNT_LAST) begin
                            stable[i] <= sync2[i];
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end
        end else begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) stable <= '0;
                else          stable <= sync2;
            end
        end
    endgenerate

    always_comb begin
        edge_hit = '0;
        case (EDGE_MODE)
            1:       edge_hit = ~stable & prev;
            2:       edge_hit = stable ^ prev;
            default: edge_hit = stable & ~prev;
        endcase
    end

    always_comb begin
        clear_bits = '0;
        if (wr_en && address == 2'd2) clear_bits = writedata[WIDTH-1:0];
    end

    // Set has priority over a simultaneous write-1-to-clear so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= IRQ_RESET_MASK;
            irq          <= 1'b0;
        end else begin
            prev         <= stable;
            edge_capture <= (edge_capture & ~clear_bits) | edge_hit;
            if (wr_en && address == 2'd1) irq_mask <= writedata[WIDTH-1:0];
            irq          <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = stable;
            2'd1:    read_mux[WIDTH-1:0] = irq_mask;
            2'd2:    read_mux[WIDTH-1:0] = edge_capture;
            default: read_mux = INFO_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= read_mux;
    end

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Directed bench: four builds (plain rising, debounced rising, falling, any edge)
// share one Avalon bus and are checked with immediate assertions.
module tb_avalon_pio_in_edge;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in0, in1, in2, in3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int n_checks = 0;
    int n_fails  = 0;

    avalon_pio_in_edge #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0), .IRQ_RESET_MASK(4'h0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));
    avalon_pio_in_edge #(.WIDTH(4), .DEBOUNCE_CYCLES(3), .EDGE_MODE(0), .IRQ_RESET_MASK(4'h0)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));
    avalon_pio_in_edge #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1), .IRQ_RESET_MASK(4'h0)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));
    avalon_pio_in_edge #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2), .IRQ_RESET_MASK(4'hA)) u3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd3), .in_port(in3), .irq(irq3));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        tick(3);
        chk("reset_rd0", rd0, 32'h0);
        chk("reset_irq0", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        tick(1);

        bus_read(2'd1);
        chk("mask_reset_u0", rd0, 32'h0);
        chk("mask_reset_u3", rd3, 32'hA);
        bus_read(2'd3);
        chk("info_u0", rd0, 32'h0000_0000);
        chk("info_u1", rd1, 32'h0003_0000);
        chk("info_u2", rd2, 32'h0000_0001);
        chk("info_u3", rd3, 32'h0000_0002);

        // basic sampling and rising capture, mask 0
        address = 2'd0;
        in0 = 4'b0101;
        tick(3);
        chk("stable_early_u0", rd0, 32'h0);
        tick(1);
        chk("stable_u0", rd0, 32'h5);
        bus_read(2'd2);
        chk("cap_u0", rd0, 32'h5);
        chk("irq_masked_u0", {31'b0, irq0}, 32'h0);

        // mask, partial clear, then full clear
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2);
        chk("cap_after_w1c4", rd0, 32'h1);
        chk("irq_on", {31'b0, irq0}, 32'h1);
        bus_write(2'd2, 32'h1);
        chk("irq_lag", {31'b0, irq0}, 32'h1);
        bus_read(2'd2);
        chk("cap_cleared", rd0, 32'h0);
        chk("irq_off", {31'b0, irq0}, 32'h0);

        // debounce: 2-cycle glitch rejected, held level accepted after 3 cycles
        address = 2'd0;
        in1 = 4'b0001;
        tick(2);
        in1 = 4'b0000;
        tick(6);
        chk("glitch_stable_u1", rd1, 32'h0);
        bus_read(2'd2);
        chk("glitch_cap_u1", rd1, 32'h0);
        address = 2'd0;
        in1 = 4'b0001;
        tick(5);
        chk("deb_not_yet_u1", rd1, 32'h0);
        tick(1);
        chk("deb_stable_u1", rd1, 32'h1);
        bus_read(2'd2);
        chk("deb_cap_u1", rd1, 32'h1);

        // falling vs any-edge builds on bit1
        in2 = 4'b0010; in3 = 4'b0010;
        tick(5);
        bus_read(2'd2);
        chk("rise_u2_none", rd2, 32'h0);
        chk("rise_u3_cap", rd3, 32'h2);
        in2 = 4'b0000; in3 = 4'b0000;
        tick(5);
        bus_read(2'd2);
        chk("fall_u2_cap", rd2, 32'h2);
        chk("fall_u3_held", rd3, 32'h2);
        bus_write(2'd2, 32'h2);
        bus_read(2'd2);
        chk("clr_u3", rd3, 32'h0);
        in2 = 4'b0010; in3 = 4'b0010;
        tick(5);
        bus_read(2'd2);
        chk("rise2_u2_none", rd2, 32'h0);
        chk("rise2_u3_cap", rd3, 32'h2);

        // set wins over a same-cycle clear on bit2
        in0 = 4'b0001;
        tick(5);
        in0 = 4'b0101;
        tick(3);
        bus_write(2'd2, 32'h4);
        bus_read(2'd2);
        chk("set_beats_clr", rd0, 32'h4);

        // async reset in the middle of a debounce with captures pending
        bus_write(2'd1, 32'hF);
        in1 = 4'b0000;
        tick(2);
        bus_read(2'd1);
        chk("pre_reset_mask", rd0, 32'hF);
        chk("pre_reset_irq", {31'b0, irq0}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("async_rd0", rd0, 32'h0);
        chk("async_irq0", {31'b0, irq0}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        bus_read(2'd2);
        chk("post_cap_u0", rd0, 32'h0);
        bus_read(2'd1);
        chk("post_mask_u0", rd0, 32'h0);
        chk("post_mask_u3", rd3, 32'hA);
        bus_read(2'd0);
        chk("post_stable_u1", rd1, 32'h0);
        bus_read(2'd3);
        chk("post_info_u1", rd1, 32'h0003_0000);
        tick(3);
        bus_read(2'd2);
        chk("held_high_cap_u0", rd0, 32'h5);
        chk("held_high_irq_u3", {31'b0, irq3}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
